display_scan_mux: RTL and testbench

//  Time-multiplexes N_DIGITS hex values onto one shared seven-segment decoder input.
//  It drives one digit enable at a time, with a programmable refresh divider and

---
 rtl/display_scan_mux.sv | 108 ++++++++++
 tb/tb_display_scan_mux.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// Time-multiplexes N_DIGITS values onto one shared seven-segment decoder input,
// enabling one digit at a time with programmable drive length and blank gaps between digits.
module display_scan_mux #(
  parameter int N_DIGITS      = 4,
  parameter int DATA_W        = 4,
  parameter int DIV           = 3,
  parameter int BLANK_CYCLES  = 1,
  parameter bit EN_ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_DIGITS*DATA_W-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]          blank_mask,
  input  logic                         hold,
  output logic [N_DIGITS-1:0]          en,
  output logic [DATA_W-1:0]            seg_data,
  output logic [$clog2(N_DIGITS)-1:0]  digit_idx,
  output logic                         frame_tick
);

  localparam int IDX_W   = $clog2(N_DIGITS);
  localparam int CNT_MAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    DRIVE_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] EN_OFF     = {N_DIGITS{EN_ACTIVE_LOW}};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      digit_idx_q;
  logic [N_DIGITS-1:0]   en_q;
  logic [DATA_W-1:0]     seg_q;
  logic                  tick_q;

  logic [DATA_W-1:0]     sel_digit_d;
  logic [N_DIGITS-1:0]   en_drive_d;
  logic [IDX_W-1:0]      idx_next_d;
  logic                  wrap_d;

  // Digit value and enable pattern loaded at the start of each drive slot.
  always_comb begin
    sel_digit_d = '0;
    en_drive_d  = EN_OFF;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (digit_idx_q == IDX_W'(k)) begin
        sel_digit_d   = digits_in[k*DATA_W +: DATA_W];
        en_drive_d[k] = EN_ACTIVE_LOW ^ ~blank_mask[k];
      end
    end
  end

  always_comb begin
    wrap_d     = (digit_idx_q == IDX_LAST);
    idx_next_d = wrap_d ? '0 : digit_idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      digit_idx_q <= '0;
      en_q        <= EN_OFF;
      seg_q       <= '0;
      tick_q      <= 1'b0;
    end else if (hold) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= ST_DRIVE;
            cnt_q   <= '0;
            seg_q   <= sel_digit_d;
            en_q    <= en_drive_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          // Enables drop before the index moves so two digits never overlap.
          if (cnt_q == DRIVE_LAST) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            en_q        <= EN_OFF;
            digit_idx_q <= idx_next_d;
            tick_q      <= wrap_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign en         = en_q;
  assign seg_data   = seg_q;
  assign digit_idx  = digit_idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: a slot-position model predicts each cycle,
// expectations flow through a scoreboard queue and are checked with immediate assertions.
module tb_display_scan_mux;

  localparam int N     = 4;
  localparam int W     = 4;
  localparam int DV    = 3;
  localparam int BL    = 1;
  localparam int P     = DV + BL;
  localparam int FRAME = N * P;

  logic           clk = 1'b0;
  logic           reset;
  logic           hold;
  logic [N*W-1:0] digits;
  logic [N-1:0]   mask;
  logic [N-1:0]   en;
  logic [W-1:0]   seg_data;
  logic [1:0]     digit_idx;
  logic           frame_tick;

  always #5 clk = ~clk;

  display_scan_mux #(
    .N_DIGITS(N), .DATA_W(W), .DIV(DV), .BLANK_CYCLES(BL), .EN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .digits_in(digits),
    .blank_mask(mask),
    .hold(hold),
    .en(en),
    .seg_data(seg_data),
    .digit_idx(digit_idx),
    .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [N-1:0] en;
    logic [W-1:0] seg;
    logic [1:0]   idx;
    logic         tick;
  } obs_t;

  obs_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Model state: cycles since reset release, plus the last driven pattern.
  int           pos   = 0;
  logic [N-1:0] m_en  = 4'hF;
  logic [W-1:0] m_seg = '0;
  logic [1:0]   m_idx = '0;

  task automatic push_next();
    obs_t e;
    int   q, ph, sl;
    logic tk;
    if (reset) begin
      pos   = 0;
      m_en  = 4'hF;
      m_seg = '0;
      m_idx = '0;
      e     = '{m_en, m_seg, m_idx, 1'b0};
    end else if (hold) begin
      e = '{m_en, m_seg, m_idx, 1'b0};
    end else begin
      q  = pos + 1;
      ph = q % P;
      sl = (q / P) % N;
      tk = 1'b0;
      if (ph < BL) begin
        m_en = 4'hF;
        tk   = (ph == 0) && (sl == 0);
      end else if (ph == BL) begin
        m_seg = digits[sl*W +: W];
        m_en  = 4'hF;
        if (!mask[sl]) m_en[sl] = 1'b0;
      end
      m_idx = 2'(sl);
      pos   = q;
      e     = '{m_en, m_seg, m_idx, tk};
    end
    sb.push_back(e);
  endtask

  task automatic cycle(input string tag);
    obs_t exp_v, got;
    push_next();
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    got   = '{en, seg_data, digit_idx, frame_tick};
    checks++;
    assert (got === exp_v) else begin
      failures++;
      $error("FAIL %s pos=%0d: got en=%b seg=%h idx=%0d tick=%b, expected en=%b seg=%h idx=%0d tick=%b",
             tag, pos, got.en, got.seg, got.idx, got.tick, exp_v.en, exp_v.seg, exp_v.idx, exp_v.tick);
    end
    checks++;
    assert ($countones(~en) <= 1) else begin
      failures++;
      $error("FAIL onehot_%s: got en=%b, expected at most one low bit", tag, en);
    end
  endtask

  int tick_at;

  initial begin
    reset  = 1'b1;
    hold   = 1'b0;
    mask   = '0;
    digits = 16'h32F9;

    repeat (2) cycle("reset");
    reset = 1'b0;

    repeat (FRAME) cycle("frame1");

    tick_at = -1;
    for (int i = 1; i <= FRAME; i++) begin
      cycle("frame2");
      if (frame_tick) tick_at = i;
    end
    checks++;
    assert (tick_at == FRAME) else begin
      failures++;
      $error("FAIL tick_period: got %0d, expected %0d", tick_at, FRAME);
    end

    // Change digit 0 during its second drive cycle; the slot must keep the snapshot.
    repeat (2) cycle("snap_pre");
    digits = 16'h32F5;
    repeat (15) cycle("snap_next");

    mask = 4'b0100;
    repeat (15) cycle("masked");
    mask = '0;

    repeat (6) cycle("pre_hold");
    hold = 1'b1;
    repeat (5) cycle("hold");
    hold = 1'b0;
    repeat (4) cycle("post_hold");

    reset = 1'b1;
    cycle("reset_mid");
    reset = 1'b0;
    repeat (FRAME + 2) cycle("restart");

    hold  = 1'b1;
    reset = 1'b1;
    cycle("reset_over_hold");
    reset = 1'b0;
    repeat (2) cycle("hold_after_reset");
    hold = 1'b0;
    repeat (8) cycle("resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
